usb_txn_ctrl: RTL and testbench
===============================

# usb_txn_ctrl

Parametrised host-side transaction controller for the USB-style link layer. It sequences one transaction per `start`: token, then data, then handshake. It drives the token, data and handshake sender/receiver sub-blocks through one-cycle start strobes and done inputs. Unlike the first-generation FSM, it supports both directions with full-transaction retry, has a configurable retry limit, a receive timeout and an abort input, and reports status and retry count.

## Interface
Parameters:
- `MAX_RETRY`, default 8: number of retries after the first attempt. Total attempts = MAX_RETRY+1. Must be ≥ 0.
- `TIMEOUT`, default 255: cycles allowed in a receive state before the attempt is declared failed. Must be ≥ 2.
- `RC_W`, default `$clog2(MAX_RETRY+1)`, minimum 1: width of the retry counter.

Ports:
- Clock and reset: clock `clk`; reset `rst_l`, asynchronous, active-low.
- `start` in 1: begin a transaction. Sampled only in IDLE.
- `dir` in 1: 1 = OUT (host writes data), 0 = IN (host reads data). Latched on accepted `start`.
- `abort` in 1: terminate the current transaction.
- `done_send_token`, `done_send_data`, `done_send_hand` in 1: sender completion pulses.
- `r_data_done` in 1: data receiver finished.
- `r_data_ok` in 1: CRC/PID good. Qualified by `r_data_done`.
- `r_hand_done` in 1: handshake receiver finished.
- `r_hand_ack`, `r_hand_nak` in 1: decoded PID. Qualified by `r_hand_done`. Done with neither flag set = corrupt handshake.
- `start_send_token`, `start_send_data`, `start_recv_data`, `start_recv_hand`, `start_send_hand` out 1: one-cycle registered strobes.
- `send_ack` out 1: handshake type for `start_send_hand`, 1 = ACK, 0 = NAK. Held stable while in SEND_HAND.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on transaction end.
- `success` out 1: valid with `done`, held until the next accepted `start`.
- `err_timeout`, `err_retry`, `err_abort` out 1: failure cause. Valid with `done`, held until the next accepted `start`.
- `retry_cnt` out RC_W: number of failed attempts in the current or last transaction.

## Operation
- States: IDLE, TOKEN, OUT_DATA, WAIT_HAND, IN_DATA, SEND_HAND.
- IDLE, `start`=1: latch `dir`; clear `retry_cnt`, `success` and the err flags; go to TOKEN.
- TOKEN, `done_send_token`: go to OUT_DATA if `dir`=1, otherwise IN_DATA.
- OUT_DATA, `done_send_data`: go to WAIT_HAND.
- WAIT_HAND:
  - `r_hand_done` & `r_hand_ack`: success.
  - `r_hand_done` with NAK or corrupt: failure.
  - timeout: failure with timeout cause.
- IN_DATA:
  - `r_data_done` & `r_data_ok`: go to SEND_HAND with `send_ack`=1.
  - `r_data_done` & !`r_data_ok`: go to SEND_HAND with `send_ack`=0.
  - timeout: failure with timeout cause; no handshake is sent.
- SEND_HAND, `done_send_hand`: success if `send_ack`=1, otherwise failure.
- Failure handling:
  - If `retry_cnt` < MAX_RETRY: increment `retry_cnt` and go to TOKEN. The whole transaction is retried.
  - Otherwise: go to IDLE with `done`=1, `success`=0, `err_retry`=1. Also set `err_timeout`=1 if the final failure was a timeout.
- Success: go to IDLE with `done`=1 and `success`=1.
- `abort`=1 in any non-IDLE state: go to IDLE with `done`=1, `success`=0, `err_abort`=1. `abort` in IDLE is ignored.
- Done inputs that do not belong to the current state are ignored.

## Timing
- Reset: state IDLE. All outputs 0, including strobes, `busy`, `done`, `success`, err flags, `send_ack` and `retry_cnt`.
- Each start strobe is high for exactly the first cycle after entering its state:
  - token strobe: every entry to TOKEN;
  - data strobe: OUT_DATA;
  - receive-data strobe: IN_DATA;
  - receive-handshake strobe: WAIT_HAND;
  - send-handshake strobe: SEND_HAND.
- A retry re-enters TOKEN and re-fires `start_send_token`.
- Latency: `start` at cycle 0 → `busy` and `start_send_token` at cycle 1. A done input at cycle n → next state and its strobe at n+1. A terminal event at cycle n → `done` at n+1, `busy`=0 at n+1.
- Done inputs may arrive in the same cycle as the strobe (cycle 1 of the state). They are honoured.
- Timeout: an 8+-bit counter is cleared on entry to WAIT_HAND or IN_DATA and increments each cycle in the state. Timeout fires in the cycle the counter equals TIMEOUT-1 with no done, i.e. the state has been held for TIMEOUT cycles.
- Priority, highest first: `abort` > done input > timeout. A done input in the timeout cycle wins.
- `start` while `busy` is ignored. `start` in the same cycle as `done` is ignored, because the FSM is in the old state.
- `retry_cnt` saturates at MAX_RETRY and never wraps.
- Reset asserted mid-transaction returns to IDLE immediately, with no `done` pulse.

## Test plan
Use MAX_RETRY=3, TIMEOUT=16.
1. **OUT success.** `start`, `dir`=1; token done at cycle 3, data done at cycle 6, handshake ACK at cycle 9 → strobes at cycles 1, 4, 7; `done`=`success`=1 at cycle 10; `retry_cnt`=0.
2. **IN with one bad CRC.** First data attempt has `r_data_ok`=0 → NAK sent (`send_ack`=0), TOKEN re-entered. Second data attempt OK → ACK sent; `done`, `success`=1, `retry_cnt`=1.
3. **OUT with every handshake NAK.** → 4 token strobes total; `done`, `success`=0, `err_retry`=1, `retry_cnt`=3.
4. **IN timeout.** No `r_data_done` → failure exactly 16 cycles after entry, with no `start_send_hand`. After 4 attempts: `err_retry`=`err_timeout`=1.
5. **Late done vs timeout.** `r_hand_done`+ACK lands in the timeout cycle → success with no retry.
6. **Abort and reset.** `abort` in OUT_DATA → `done`, `err_abort`=1 next cycle; `start` pulsed during `busy` is ignored. `rst_l` low mid-transaction → all outputs 0, no `done`.

Source files
------------

// File: rtl/usb_txn_ctrl.sv
// Host-side USB link-layer transaction sequencer: token, data, handshake,
// both directions, whole-transaction retry, receive timeout and abort.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start; status flags from last transaction held
// TOKEN     | token sender running
// OUT_DATA  | data sender running (host -> device)
// WAIT_HAND | waiting for device handshake, timed
// IN_DATA   | waiting for device data packet, timed
// SEND_HAND | handshake sender running, send_ack selects ACK/NAK
module usb_txn_ctrl #(
    parameter int MAX_RETRY = 8,
    parameter int TIMEOUT   = 255,
    parameter int RC_W      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            start,
    input  logic            dir,
    input  logic            abort,
    input  logic            done_send_token,
    input  logic            done_send_data,
    input  logic            done_send_hand,
    input  logic            r_data_done,
    input  logic            r_data_ok,
    input  logic            r_hand_done,
    input  logic            r_hand_ack,
    input  logic            r_hand_nak,
    output logic            start_send_token,
    output logic            start_send_data,
    output logic            start_recv_data,
    output logic            start_recv_hand,
    output logic            start_send_hand,
    output logic            send_ack,
    output logic            busy,
    output logic            done,
    output logic            success,
    output logic            err_timeout,
    output logic            err_retry,
    output logic            err_abort,
    output logic [RC_W-1:0] retry_cnt
);

    localparam int TW = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;

    typedef enum logic [2:0] {
        IDLE, TOKEN, OUT_DATA, WAIT_HAND, IN_DATA, SEND_HAND
    } state_t;

    state_t          state;
    logic            dir_q;
    logic [TW-1:0]   timer;
    logic            timer_exp;
    logic            ev_succ;
    logic            ev_fail;
    logic            ev_to;

    assign timer_exp = (timer == TW'(TIMEOUT - 1));

    // Terminal/failure events of the current attempt; a done input beats timeout.
    always_comb begin
        ev_succ = 1'b0;
        ev_fail = 1'b0;
        ev_to   = 1'b0;
        case (state)
            WAIT_HAND: begin
                if (r_hand_done) begin
                    // both PID flags set is an undecodable PID: treated as corrupt
                    if (r_hand_ack && !r_hand_nak) ev_succ = 1'b1;
                    else                           ev_fail = 1'b1;
                end else if (timer_exp) begin
                    ev_fail = 1'b1;
                    ev_to   = 1'b1;
                end
            end
            IN_DATA: begin
                if (!r_data_done && timer_exp) begin
                    ev_fail = 1'b1;
                    ev_to   = 1'b1;
                end
            end
            SEND_HAND: begin
                if (done_send_hand) begin
                    if (send_ack) ev_succ = 1'b1;
                    else          ev_fail = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state            <= IDLE;
            dir_q            <= 1'b0;
            timer            <= '0;
            start_send_token <= 1'b0;
            start_send_data  <= 1'b0;
            start_recv_data  <= 1'b0;
            start_recv_hand  <= 1'b0;
            start_send_hand  <= 1'b0;
            send_ack         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            success          <= 1'b0;
            err_timeout      <= 1'b0;
            err_retry        <= 1'b0;
            err_abort        <= 1'b0;
            retry_cnt        <= '0;
        end else begin
            start_send_token <= 1'b0;
            start_send_data  <= 1'b0;
            start_recv_data  <= 1'b0;
            start_recv_hand  <= 1'b0;
            start_send_hand  <= 1'b0;
            done             <= 1'b0;
            timer            <= timer + TW'(1);

            if (state != IDLE && abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                done      <= 1'b1;
                success   <= 1'b0;
                err_abort <= 1'b1;
            end else if (ev_succ) begin
                state   <= IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
                success <= 1'b1;
            end else if (ev_fail) begin
                if (retry_cnt < RC_W'(MAX_RETRY)) begin
                    retry_cnt        <= retry_cnt + RC_W'(1);
                    state            <= TOKEN;
                    start_send_token <= 1'b1;
                end else begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    success     <= 1'b0;
                    err_retry   <= 1'b1;
                    err_timeout <= ev_to;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            dir_q            <= dir;
                            retry_cnt        <= '0;
                            success          <= 1'b0;
                            err_timeout      <= 1'b0;
                            err_retry        <= 1'b0;
                            err_abort        <= 1'b0;
                            busy             <= 1'b1;
                            state            <= TOKEN;
                            start_send_token <= 1'b1;
                        end
                    end
                    TOKEN: begin
                        if (done_send_token) begin
                            if (dir_q) begin
                                state           <= OUT_DATA;
                                start_send_data <= 1'b1;
                            end else begin
                                state           <= IN_DATA;
                                start_recv_data <= 1'b1;
                                timer           <= '0;
                            end
                        end
                    end
                    OUT_DATA: begin
                        if (done_send_data) begin
                            state           <= WAIT_HAND;
                            start_recv_hand <= 1'b1;
                            timer           <= '0;
                        end
                    end
                    IN_DATA: begin
                        if (r_data_done) begin
                            state           <= SEND_HAND;
                            send_ack        <= r_data_ok;
                            start_send_hand <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Directed bench for usb_txn_ctrl (MAX_RETRY=3, TIMEOUT=16); end-of-transaction
// status is checked against a queue of expectations pushed with the stimulus.
module tb_usb_txn_ctrl;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       start, dir, abort;
    logic       done_send_token, done_send_data, done_send_hand;
    logic       r_data_done, r_data_ok, r_hand_done, r_hand_ack, r_hand_nak;
    logic       start_send_token, start_send_data, start_recv_data;
    logic       start_recv_hand, start_send_hand, send_ack;
    logic       busy, done, success, err_timeout, err_retry, err_abort;
    logic [1:0] retry_cnt;

    int errors = 0;
    int checks = 0;
    int n_tok  = 0;
    int n_sh   = 0;

    typedef struct packed {
        logic       succ;
        logic       eto;
        logic       eret;
        logic       eab;
        logic [1:0] rc;
    } exp_t;

    exp_t exp_q[$];

    usb_txn_ctrl #(.MAX_RETRY(3), .TIMEOUT(16)) dut (
        .clk(clk), .rst_l(rst_l), .start(start), .dir(dir), .abort(abort),
        .done_send_token(done_send_token), .done_send_data(done_send_data),
        .done_send_hand(done_send_hand), .r_data_done(r_data_done),
        .r_data_ok(r_data_ok), .r_hand_done(r_hand_done),
        .r_hand_ack(r_hand_ack), .r_hand_nak(r_hand_nak),
        .start_send_token(start_send_token), .start_send_data(start_send_data),
        .start_recv_data(start_recv_data), .start_recv_hand(start_recv_hand),
        .start_send_hand(start_send_hand), .send_ack(send_ack), .busy(busy),
        .done(done), .success(success), .err_timeout(err_timeout),
        .err_retry(err_retry), .err_abort(err_abort), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start_send_token) n_tok <= n_tok + 1;
        if (start_send_hand)  n_sh  <= n_sh + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_in();
        abort = 0; done_send_token = 0; done_send_data = 0; done_send_hand = 0;
        r_data_done = 0; r_data_ok = 0; r_hand_done = 0; r_hand_ack = 0; r_hand_nak = 0;
    endtask

    function automatic logic [31:0] get_outs();
        return 32'({start_send_token, start_send_data, start_recv_data, start_recv_hand,
                    start_send_hand, send_ack, busy, done, success, err_timeout,
                    err_retry, err_abort, retry_cnt});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic s, input logic t, input logic r, input logic a,
                            input logic [1:0] rc);
        exp_q.push_back({s, t, r, a, rc});
    endtask

    task automatic wait_end(input string tag, input int max_wait, output int waited);
        exp_t e;
        waited = 0;
        while (done !== 1'b1 && waited < max_wait) begin
            tick();
            waited++;
        end
        checks++;
        assert (done === 1'b1) else begin
            errors++;
            $error("FAIL %s_done: observed done=%b expected 1 within %0d cycles", tag, done, max_wait);
        end
        if (done === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_status"}, 32'({success, err_timeout, err_retry, err_abort, retry_cnt}), 32'(e));
        end
    endtask

    task automatic wait_tok(input string tag, input int max_wait, output int waited);
        waited = 0;
        while (start_send_token !== 1'b1 && waited < max_wait) begin
            tick();
            waited++;
        end
        chk({tag, "_tok_seen"}, 32'(start_send_token), 1);
    endtask

    initial begin
        int w;
        int n0;
        rst_l = 0; start = 0; dir = 0;
        clear_in();
        repeat (2) tick();
        rst_l = 1;
        tick();
        chk("reset_outs", get_outs(), 0);

        // OUT success with exact strobe cycles
        start = 1; dir = 1; tick(); start = 0;
        chk("t1_busy_c1", 32'(busy), 1);
        chk("t1_tok_c1", 32'(start_send_token), 1);
        tick(); tick(); done_send_token = 1; tick(); done_send_token = 0;
        chk("t1_data_c4", 32'(start_send_data), 1);
        chk("t1_tok_one_cycle", 32'(start_send_token), 0);
        tick(); tick(); done_send_data = 1; tick(); done_send_data = 0;
        chk("t1_rhand_c7", 32'(start_recv_hand), 1);
        tick(); tick(); r_hand_done = 1; r_hand_ack = 1;
        push_exp(1, 0, 0, 0, 2'd0);
        tick(); clear_in();
        wait_end("t1", 0, w);
        chk("t1_busy_c10", 32'(busy), 0);
        tick();
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_success_held", 32'(success), 1);

        // IN with one bad CRC, then good
        n0 = n_sh;
        start = 1; dir = 0; tick(); start = 0;
        done_send_token = 1; tick(); done_send_token = 0;
        chk("t2_rdata_strobe", 32'(start_recv_data), 1);
        r_data_done = 1; r_data_ok = 0; tick(); clear_in();
        chk("t2_nak_strobe", 32'({start_send_hand, send_ack}), 32'b10);
        done_send_hand = 1; tick(); done_send_hand = 0;
        chk("t2_retry_tok", 32'({start_send_token, retry_cnt}), 32'b101);
        done_send_token = 1; tick(); done_send_token = 0;
        r_data_done = 1; r_data_ok = 1; tick(); clear_in();
        chk("t2_ack_strobe", 32'({start_send_hand, send_ack}), 32'b11);
        done_send_hand = 1; push_exp(1, 0, 0, 0, 2'd1);
        tick(); clear_in();
        wait_end("t2", 0, w);
        tick();
        chk("t2_send_hand_count", 32'(n_sh - n0), 2);

        // OUT with every handshake refused (one corrupt)
        n0 = n_tok;
        start = 1; dir = 1; tick(); start = 0;
        for (int a = 0; a < 4; a++) begin
            done_send_token = 1; tick(); done_send_token = 0;
            done_send_data = 1; tick(); done_send_data = 0;
            r_hand_done = 1; r_hand_nak = (a != 1);
            if (a == 3) push_exp(0, 0, 1, 0, 2'd3);
            tick(); clear_in();
        end
        wait_end("t3", 0, w);
        tick();
        chk("t3_token_strobes", 32'(n_tok - n0), 4);

        // IN timeout on every attempt
        n0 = n_sh;
        start = 1; dir = 0; tick(); start = 0;
        for (int a = 0; a < 4; a++) begin
            done_send_token = 1; tick(); done_send_token = 0;
            if (a < 3) begin
                wait_tok("t4", 20, w);
                chk("t4_timeout_cycles", 32'(w), 16);
            end else begin
                push_exp(0, 1, 1, 0, 2'd3);
                wait_end("t4", 20, w);
                chk("t4_final_cycles", 32'(w), 16);
            end
        end
        tick();
        chk("t4_no_send_hand", 32'(n_sh - n0), 0);

        // handshake ACK lands in the timeout cycle
        start = 1; dir = 1; tick(); start = 0;
        done_send_token = 1; tick(); done_send_token = 0;
        done_send_data = 1; tick(); done_send_data = 0;
        repeat (15) tick();
        r_hand_done = 1; r_hand_ack = 1; push_exp(1, 0, 0, 0, 2'd0);
        tick(); clear_in();
        wait_end("t5", 0, w);

        // abort in OUT_DATA, start while busy ignored, abort in IDLE ignored
        n0 = n_tok;
        start = 1; dir = 1; tick();
        done_send_token = 1; tick(); start = 0; done_send_token = 0;
        abort = 1; push_exp(0, 0, 0, 1, 2'd0);
        tick(); abort = 0;
        wait_end("t6", 0, w);
        tick();
        chk("t6_tok_strobes", 32'(n_tok - n0), 1);
        abort = 1; tick(); abort = 0;
        chk("t6_idle_abort", 32'({busy, done, err_abort}), 32'b001);

        // reset mid-transaction
        start = 1; dir = 1; tick(); start = 0;
        done_send_token = 1; tick(); done_send_token = 0;
        #2 rst_l = 0;
        #1 chk("rst_async_outs", get_outs(), 0);
        tick();
        chk("rst_no_done", 32'(done), 0);
        rst_l = 1; tick();
        chk("rst_release_outs", get_outs(), 0);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
